dac_sample_scheduler: RTL

Sequences sample delivery into the single-bit DAC datapath. Accepts offset-binary samples from an upstream producer over a valid/ready handshake and buffers them in a small FIFO. Releases one sample per programmable sample period onto the DAC `d` input, emitting a one-cycle strobe with each release. Handles start-up priming, underrun detection and silent (midscale) output when disabled.

---
 rtl/dac_sample_scheduler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dac_sample_scheduler.sv
// Paces FIFO-buffered offset-binary samples onto the DAC d input, one per divisor+1 clocks; DAC_SCHED_RAMP_EN adds a soft ramp to midscale.
// Latency: a pushed sample is poppable from the next cycle; dac_d and sample_tick register on the divider tick.
// Backpressure: in_ready = (fill != depth), combinational from registered fill only.
module dac_sample_scheduler #(
  parameter int signalwidth = 16,
  parameter int depthlog2   = 2,
  parameter int divwidth    = 12,
  parameter int rampstep    = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [divwidth-1:0]    divisor,
  input  logic [signalwidth-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [signalwidth-1:0] dac_d,
  output logic                   sample_tick,
  output logic                   underrun,
  input  logic                   clear_underrun,
  output logic [depthlog2:0]     fill
);

`ifdef DAC_SCHED_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  localparam int DEPTH = 1 << depthlog2;
  localparam logic [depthlog2:0] FULL = (depthlog2+1)'(DEPTH);
  localparam logic [depthlog2:0] PRIME_LVL = (DEPTH < 2) ? (depthlog2+1)'(DEPTH) : (depthlog2+1)'(2);
  localparam logic [signalwidth-1:0] MID = {1'b1, {(signalwidth-1){1'b0}}};
  localparam logic [signalwidth-1:0] STEP = signalwidth'(rampstep);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t state, state_nxt;

  logic [signalwidth-1:0] mem [DEPTH];
  logic [depthlog2-1:0]   wr_ptr, rd_ptr;
  logic [divwidth-1:0]    cnt;
  logic [signalwidth-1:0] ramp_next;
  logic push, pop, urun_set, div_run, tick, ramp_go;

  assign in_ready = (fill != FULL);
  assign push     = in_valid && in_ready;

  // In the ramp build the divider keeps running in IDLE until dac_d settles at MID
  assign div_run  = (state != IDLE) || (RAMP_ON && (dac_d != MID));
  assign tick     = div_run && (cnt == '0);
  assign pop      = enable && (state == RUN) && tick && (fill != '0);
  assign urun_set = enable && (state == RUN) && tick && (fill == '0);
  assign ramp_go  = RAMP_ON && tick && (state != RUN) && (dac_d != MID);

  always_comb begin
    ramp_next = MID;
    if (dac_d > MID) begin
      if ((dac_d - MID) > STEP) ramp_next = dac_d - STEP;
    end else if ((MID - dac_d) > STEP) begin
      ramp_next = dac_d + STEP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = PRIME;
      PRIME:   if (fill >= PRIME_LVL) state_nxt = RUN;
      RUN:     if (urun_set) state_nxt = PRIME;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     cnt <= '0;
    else if (!div_run || cnt == '0)   cnt <= divisor;
    else                              cnt <= cnt - 1'b1;
  end

  // Storage has no reset; pointers and fill define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dac_d       <= MID;
      sample_tick <= 1'b0;
    end else if (!RAMP_ON && !enable) begin
      dac_d       <= MID;
      sample_tick <= 1'b0;
    end else if (pop) begin
      dac_d       <= mem[rd_ptr];
      sample_tick <= 1'b1;
    end else if (ramp_go) begin
      dac_d       <= ramp_next;
      sample_tick <= 1'b1;
    end else begin
      sample_tick <= 1'b0;
    end
  end

  // A set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            underrun <= 1'b0;
    else if (urun_set)       underrun <= 1'b1;
    else if (clear_underrun) underrun <= 1'b0;
  end

endmodule
